// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA receive-side timing recovery
// Locks onto hs/vs timing, recovers x/y/de, measures line/frame length and flags violations.
module vga_sync_rx #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk_25,
  input  logic       rst_n,
  input  logic       hs,
  input  logic       vs,
  input  logic [7:0] rgb,
  output logic       locked,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [7:0] rgb_o,
  output logic [9:0] h_len,
  output logic [9:0] v_len,
  output logic       sync_err
);
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  localparam logic [10:0] LP_H_TOTAL  = 11'(H_TOTAL);
  localparam logic [10:0] LP_H_SYNC   = 11'(H_SYNC);
  localparam logic [10:0] LP_V_TOTAL  = 11'(V_TOTAL);
  localparam logic [10:0] LP_H_OFF    = 11'(H_SYNC + H_BP);
  localparam logic [10:0] LP_V_OFF    = 11'(V_SYNC + V_BP);
  localparam logic [10:0] LP_H_ACTIVE = 11'(H_ACTIVE);
  localparam logic [10:0] LP_V_ACTIVE = 11'(V_ACTIVE);
  localparam logic [7:0]  LP_LOCK     = 8'(LOCK_FRAMES);

  logic        r_hs_r, r_hs_rr, r_vs_r, r_vs_rr;
  logic [7:0]  r_rgb_r, r_rgb_rr;
  logic [9:0]  r_h_ctr, r_v_ctr;
  logic        r_vpend;
  logic [7:0]  r_good, w_good_nx;
  state_t      r_state, w_state_nx;
  logic        r_de, r_sync_err;
  logic [9:0]  r_x, r_y, r_h_len, r_v_len;
  logic [7:0]  r_rgb_o;

  logic        w_hfall, w_vfall, w_hrise, w_frame, w_viol, w_de;
  logic [10:0] w_h_meas, w_v_meas;
  logic signed [10:0] w_hv, w_vv;

  assign w_hfall  = r_hs_rr & ~r_hs_r;
  assign w_vfall  = r_vs_rr & ~r_vs_r;
  assign w_hrise  = ~r_hs_rr & r_hs_r;
  assign w_h_meas = {1'b0, r_h_ctr} + 11'd1;
  assign w_v_meas = {1'b0, r_v_ctr} + 11'd1;
  assign w_frame  = w_hfall & (r_vpend | w_vfall);

  // Watchdog fires only on the step into 1023, so a stuck hs reports once.
  assign w_viol = (w_hfall & (w_h_meas != LP_H_TOTAL))
                | (w_hrise & (w_h_meas != LP_H_SYNC))
                | (w_frame & (w_v_meas != LP_V_TOTAL))
                | (~w_hfall & (r_h_ctr == 10'd1022));

  assign w_hv = $signed({1'b0, r_h_ctr}) - $signed(LP_H_OFF);
  assign w_vv = $signed({1'b0, r_v_ctr}) - $signed(LP_V_OFF);
  assign w_de = (w_state_nx == LOCKED)
              & ~w_hv[10] & (w_hv < $signed(LP_H_ACTIVE))
              & ~w_vv[10] & (w_vv < $signed(LP_V_ACTIVE));

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      r_hs_r   <= 1'b1;
      r_hs_rr  <= 1'b1;
      r_vs_r   <= 1'b1;
      r_vs_rr  <= 1'b1;
      r_rgb_r  <= '0;
      r_rgb_rr <= '0;
    end else begin
      r_hs_r   <= hs;
      r_hs_rr  <= r_hs_r;
      r_vs_r   <= vs;
      r_vs_rr  <= r_vs_r;
      r_rgb_r  <= rgb;
      r_rgb_rr <= r_rgb_r;
    end
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      r_h_ctr <= '0;
      r_v_ctr <= '0;
      r_vpend <= 1'b0;
      r_h_len <= '0;
      r_v_len <= '0;
    end else begin
      if (w_hfall) r_h_ctr <= '0;
      else if (r_h_ctr != 10'd1023) r_h_ctr <= r_h_ctr + 10'd1;

      if (w_frame) begin
        r_v_ctr <= '0;
        r_vpend <= 1'b0;
      end else begin
        if (w_vfall) r_vpend <= 1'b1;
        if (w_hfall && r_v_ctr != 10'd1023) r_v_ctr <= r_v_ctr + 10'd1;
      end

      if (w_hfall && r_state == LOCKED) r_h_len <= w_h_meas[9:0];
      if (w_frame && r_state == LOCKED) r_v_len <= w_v_meas[9:0];
    end
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      r_state <= SEARCH;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_good  <= w_good_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_good_nx  = r_good;
    case (r_state)
      SEARCH: begin
        w_good_nx = '0;
        if (w_frame) w_state_nx = CHECK;
      end
      CHECK: begin
        if (w_viol) begin
          w_state_nx = SEARCH;
          w_good_nx  = '0;
        end else begin
          if (w_frame) w_good_nx = r_good + 8'd1;
          if (r_good >= LP_LOCK) w_state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (w_viol) begin
          w_state_nx = SEARCH;
          w_good_nx  = '0;
        end
      end
      default: begin
        w_state_nx = SEARCH;
        w_good_nx  = '0;
      end
    endcase
  end

  // Outputs follow the next state so de/x/y drop on the same edge lock is lost.
  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      r_de       <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_rgb_o    <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_de       <= w_de;
      r_x        <= w_de ? w_hv[9:0] : 10'd0;
      r_y        <= w_de ? w_vv[9:0] : 10'd0;
      r_rgb_o    <= w_de ? r_rgb_rr : 8'd0;
      r_sync_err <= w_viol & (r_state != SEARCH);
    end
  end

  assign locked   = (r_state == LOCKED);
  assign de       = r_de;
  assign x        = r_x;
  assign y        = r_y;
  assign rgb_o    = r_rgb_o;
  assign h_len    = r_h_len;
  assign v_len    = r_v_len;
  assign sync_err = r_sync_err;
endmodule
